shifter_arbiter_16bit: RTL
==========================

// Module: shifter_arbiter_16bit
// PURPOSE
//   Shares a single 16-bit left/right rotate stage between two requesters.
//   - Round-robin arbiter selects one request per cycle.
//   - The winning operands drive the shared shift stage; its result is captured in a one-entry output register.
//   - The result is returned with the winner's ID over a valid/ready handshake.
//   - Sits between two datapath clients (e.g. ALU, address unit) and one Shifters_stage_16bit instance.
// PARAMETERS
//   none (width fixed at 16 data bits, 4 amount bits, matching the shared stage)
// PORTS
//   clk         in   1   rising-edge clock
//   reset       in   1   synchronous, active-high reset
//   req0_valid  in   1   requester 0 has an operation pending
//   req0_ready  out  1   requester 0 operation accepted this cycle
//   req0_a      in   16  requester 0 operand
//   req0_amt    in   4   requester 0 rotate amount (0..15)
//   req0_dir    in   1   requester 0 direction: 0 = left, 1 = right
//   req1_valid  in   1   requester 1 has an operation pending
//   req1_ready  out  1   requester 1 operation accepted this cycle
//   req1_a      in   16  requester 1 operand
//   req1_amt    in   4   requester 1 rotate amount
//   req1_dir    in   1   requester 1 direction
//   res_valid   out  1   res_data/res_id hold a result
//   res_ready   in   1   consumer accepts result this cycle
//   res_data    out  16  rotated result
//   res_id      out  1   requester that issued this result (0/1)
// BEHAVIOUR
// - Clock and reset: single clock domain. reset is sampled on the clk rising edge only (synchronous, active-high).
// - Reset values: res_valid=0, res_data=16'h0000, res_id=0, last_grant=1 (requester 0 wins the first tie).
//   req*_ready are combinational and are therefore 0 while reset is high.
// - States, carried by res_valid:
//   - EMPTY (res_valid=0): output register is free.
//   - FULL (res_valid=1): output register holds an unconsumed result.
// - slot_free = !res_valid | res_ready. This allows back-to-back throughput of one op per cycle.
// - Grant (combinational):
//   - Only req0_valid: grant 0.
//   - Only req1_valid: grant 1.
//   - Both valid: grant !last_grant.
//   - Neither valid: no grant.
// - req0_ready = slot_free & grant==0 & req0_valid. req1_ready is defined likewise. At most one ready is high per cycle.
// - Handshake: a request completes on a cycle where req*_valid & req*_ready are both high.
//   - Requesters hold a, amt, dir and valid stable until ready.
//   - Ready may depend combinationally on valid.
//   - Valid must not depend on ready.
// - Datapath: the grant mux drives the shared stage.
//   - y = dir ? rotate_right(a, amt) : rotate_left(a, amt).
//   - Bits wrap around; nothing is lost or zero-filled.
//   - amt=0 passes a unchanged.
// - Capture, on the clk edge after an accepted request:
//   - res_data <= y, res_id <= grant, res_valid <= 1, last_grant <= grant.
//   - Latency: 1 cycle from accept to res_valid.
// - Transitions:
//   - EMPTY and request accepted -> FULL.
//   - FULL and res_ready and new accept -> FULL, loaded with the new result (same-cycle drain and refill).
//   - FULL and res_ready with no request -> EMPTY.
//   - FULL and !res_ready -> FULL: res_data and res_id held, both req*_ready=0, last_grant unchanged.
// - last_grant updates only on an accept, so a stalled winner keeps its priority turn.
// - Fairness: with both requesters valid continuously and res_ready=1, grants strictly alternate 0,1,0,1...
// - Reset mid-operation: a pending result is discarded next edge (res_valid=0), and no handshake completes in the reset cycle.
// - A requester dropping valid before ready (protocol violation) simply loses its slot. No state is corrupted.
// TESTING
//   T1: reset held 2 cycles, then released -> res_valid=0, req0_ready=req1_ready=0 until a valid arrives.
//   T2: req0 a=16'h1234 amt=4 dir=0, res_ready=1 -> req0_ready same cycle; next cycle res_valid=1, res_data=16'h2341, res_id=0.
//   T3: req1 a=16'h1234 amt=4 dir=1 -> res_data=16'h4123, res_id=1. Then a=16'h8001 amt=0 -> 16'h8001. Then a=16'h8001 amt=15 dir=0 -> 16'hC000.
//   T4: both valid for 4 ops, res_ready=1 -> grants 0,1,0,1; res_valid high 4 consecutive cycles; ids 0,1,0,1.
//   T5: res_ready=0 with result FULL while both requesters are valid for 3 cycles -> res_data and res_id stable, both readys 0.
//       Then res_ready=1 -> same-cycle drain plus accept of the correct round-robin winner.
//   T6: reset asserted the cycle after an accept (res_valid about to rise) -> res_valid=0 next edge; after release, req0 wins the first tie.

Source files
------------

// File: rtl/shifter_arbiter_16bit_if.sv
`default_nettype none
// ============================================================================
// Module      : shifter_arbiter_16bit_if
// Description : Request/result bundle for the two-client shared rotate stage.
//               master = requesters + result consumer, slave = arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
interface shifter_arbiter_16bit_if;
    logic        req0_valid;
    logic        req0_ready;
    logic [15:0] req0_a;
    logic [3:0]  req0_amt;
    logic        req0_dir;
    logic        req1_valid;
    logic        req1_ready;
    logic [15:0] req1_a;
    logic [3:0]  req1_amt;
    logic        req1_dir;
    logic        res_valid;
    logic        res_ready;
    logic [15:0] res_data;
    logic        res_id;

    modport master (
        output req0_valid, req0_a, req0_amt, req0_dir,
        output req1_valid, req1_a, req1_amt, req1_dir,
        output res_ready,
        input  req0_ready, req1_ready,
        input  res_valid, res_data, res_id
    );

    modport slave (
        input  req0_valid, req0_a, req0_amt, req0_dir,
        input  req1_valid, req1_a, req1_amt, req1_dir,
        input  res_ready,
        output req0_ready, req1_ready,
        output res_valid, res_data, res_id
    );
endinterface
`default_nettype wire

// File: rtl/shifter_arbiter_16bit.sv
`default_nettype none
// ============================================================================
// Module      : shifter_arbiter_16bit
// Description : Round-robin arbiter sharing one 16-bit rotate stage between
//               two requesters; result held in a one-entry output register
//               and returned with the winner's ID over valid/ready.
// Revision    : 1.0 - initial release
// ============================================================================
module shifter_arbiter_16bit (
    input  wire logic                    clk,
    input  wire logic                    reset,
    shifter_arbiter_16bit_if.slave       bus
);

    typedef enum logic [0:0] {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t      state_q;
    logic [15:0] data_q;
    logic        id_q;
    logic        last_grant_q;

    logic        slot_free;
    logic        grant1;
    logic        ready0;
    logic        ready1;
    logic        accept;
    logic [15:0] op_a;
    logic [3:0]  op_amt;
    logic        op_dir;
    logic [4:0]  amt_inv;
    logic [15:0] data_d;

    // Output register can take a new result if empty or draining this cycle.
    assign slot_free = (state_q == EMPTY) | bus.res_ready;

    // Requester 1 wins when alone, or on a tie when requester 0 had the last turn.
    assign grant1 = bus.req1_valid & (~bus.req0_valid | ~last_grant_q);

    // Ready is suppressed during reset so no handshake completes in that cycle.
    assign ready0 = ~reset & slot_free & bus.req0_valid & ~grant1;
    assign ready1 = ~reset & slot_free & bus.req1_valid &  grant1;
    assign accept = ready0 | ready1;

    assign bus.req0_ready = ready0;
    assign bus.req1_ready = ready1;

    // Grant mux feeding the shared rotate stage.
    assign op_a   = grant1 ? bus.req1_a   : bus.req0_a;
    assign op_amt = grant1 ? bus.req1_amt : bus.req0_amt;
    assign op_dir = grant1 ? bus.req1_dir : bus.req0_dir;

    // Complementary shift distance; 16 makes the wrap term vanish for amt=0.
    assign amt_inv = 5'd16 - {1'b0, op_amt};

    assign data_d = op_dir ? ((op_a >> op_amt) | (op_a << amt_inv))
                           : ((op_a << op_amt) | (op_a >> amt_inv));

    // Occupancy FSM plus result capture; last_grant moves only on an accept.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= EMPTY;
            data_q       <= 16'h0000;
            id_q         <= 1'b0;
            last_grant_q <= 1'b1;
        end else if (accept) begin
            state_q      <= FULL;
            data_q       <= data_d;
            id_q         <= grant1;
            last_grant_q <= grant1;
        end else if ((state_q == FULL) && bus.res_ready) begin
            state_q      <= EMPTY;
        end
    end

    assign bus.res_valid = (state_q == FULL);
    assign bus.res_data  = data_q;
    assign bus.res_id    = id_q;

endmodule
`default_nettype wire
